// File: rtl/modport_cpu.sv
// modport_cpu: single-cycle 32-bit MIPS-subset core. Each rising clock edge
// retires one instruction. The register file, ALU, data memory and next-PC
// logic are internal. Key datapath nodes are exported for observation.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   InstMem_Out  instruction word fetched from external memory at PCOut
//   PCOut        current PC (register)
//   PC_In        next-PC value, loaded into PCOut at the next edge
//   A            ALU operand A (rs read data)
//   B            ALU operand B (rt read data or extended immediate)
//   rd2          rt read data (store data)
//   datamem_out  data memory read data at the ALU-result word address
//   mux5_out     writeback data (memory data for lw, else ALU/shift result)
module modport_cpu #(
    parameter int          DMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstMem_Out,
    output logic [31:0] PCOut,
    output logic [31:0] PC_In,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [31:0] rd2,
    output logic [31:0] datamem_out,
    output logic [31:0] mux5_out
);

    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLL  = 3'd6;
    localparam logic [2:0] ALU_SRL  = 3'd7;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] jta;

    assign opcode = InstMem_Out[31:26];
    assign rs     = InstMem_Out[25:21];
    assign rt     = InstMem_Out[20:16];
    assign rd     = InstMem_Out[15:11];
    assign shamt  = InstMem_Out[10:6];
    assign funct  = InstMem_Out[5:0];
    assign imm    = InstMem_Out[15:0];
    assign jta    = InstMem_Out[25:0];

    // State
    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q   [32];
    logic [31:0] dmem_q [DMEM_WORDS];

    // Control and datapath nodes
    logic [31:0] rs_data, rt_data, ext_imm, alu_res;
    logic [31:0] pc_plus4, branch_target;
    logic [2:0]  alu_ctl;
    logic        use_imm, wr_en, mem_we, mem_to_reg, branch_taken, jump;
    logic [4:0]  wr_addr;
    logic [DMEM_AW-1:0] dmem_addr;

    // $0 is hard-wired to zero on the read side as well as never written.
    assign rs_data = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_data = (rt == 5'd0) ? 32'd0 : rf_q[rt];

    // NOTE: every signal assigned in this block gets a default first so that
    // unsupported opcodes/functs fall through to a NOP and no latch is inferred.
    always_comb begin
        alu_ctl      = ALU_NONE;
        use_imm      = 1'b0;
        ext_imm      = {{16{imm[15]}}, imm};
        wr_en        = 1'b0;
        wr_addr      = rt;
        mem_we       = 1'b0;
        mem_to_reg   = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                wr_addr = rd;
                wr_en   = 1'b1;
                case (funct)
                    FN_ADD:  alu_ctl = ALU_ADD;
                    FN_SUB:  alu_ctl = ALU_SUB;
                    FN_AND:  alu_ctl = ALU_AND;
                    FN_OR:   alu_ctl = ALU_OR;
                    FN_SLT:  alu_ctl = ALU_SLT;
                    FN_SLL:  alu_ctl = ALU_SLL;
                    FN_SRL:  alu_ctl = ALU_SRL;
                    default: wr_en   = 1'b0;
                endcase
            end
            OP_ADDI: begin use_imm = 1'b1; alu_ctl = ALU_ADD; wr_en = 1'b1; end
            OP_SLTI: begin use_imm = 1'b1; alu_ctl = ALU_SLT; wr_en = 1'b1; end
            OP_ANDI: begin
                use_imm = 1'b1; ext_imm = {16'd0, imm}; alu_ctl = ALU_AND; wr_en = 1'b1;
            end
            OP_ORI: begin
                use_imm = 1'b1; ext_imm = {16'd0, imm}; alu_ctl = ALU_OR; wr_en = 1'b1;
            end
            OP_LW: begin
                use_imm = 1'b1; alu_ctl = ALU_ADD; wr_en = 1'b1; mem_to_reg = 1'b1;
            end
            OP_SW:   begin use_imm = 1'b1; alu_ctl = ALU_ADD; mem_we = 1'b1; end
            OP_BEQ:  branch_taken = (rs_data == rt_data);
            OP_BNE:  branch_taken = (rs_data != rt_data);
            OP_J:    jump = 1'b1;
            default: ;
        endcase
    end

    assign A   = rs_data;
    assign B   = use_imm ? ext_imm : rt_data;
    assign rd2 = rt_data;

    always_comb begin
        case (alu_ctl)
            ALU_ADD: alu_res = A + B;
            ALU_SUB: alu_res = A - B;
            ALU_AND: alu_res = A & B;
            ALU_OR:  alu_res = A | B;
            ALU_SLT: alu_res = {31'd0, $signed(A) < $signed(B)};
            ALU_SLL: alu_res = rt_data << shamt;
            ALU_SRL: alu_res = rt_data >> shamt;
            default: alu_res = 32'd0;
        endcase
    end

    // Word address; bits above the memory depth wrap around.
    assign dmem_addr   = alu_res[DMEM_AW+1:2];
    assign datamem_out = dmem_q[dmem_addr];
    assign mux5_out    = mem_to_reg ? datamem_out : alu_res;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};

    always_comb begin
        pc_d = pc_plus4;
        if (jump)
            pc_d = {pc_plus4[31:28], jta, 2'b00};
        else if (branch_taken)
            pc_d = branch_target;
    end

    assign PC_In = pc_d;
    assign PCOut = pc_q;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge combinational values consistently.
    // NOTE: the register file and data memory are cleared on reset because a
    // program restart must observe all-zero architectural state; this forces
    // flop-based storage rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (wr_en && (wr_addr != 5'd0)) rf_q[wr_addr] <= mux5_out;
            if (mem_we) dmem_q[dmem_addr] <= rd2;
        end
    end

endmodule

// File: tb/tb_modport_cpu.sv
// Testbench for modport_cpu: directed instruction stream with hand-computed
// expectations pushed into a scoreboard queue; a monitor on the falling edge
// pops and compares them against the DUT's observed datapath nodes.
module tb_modport_cpu;

    typedef enum logic [2:0] {S_PC, S_PCIN, S_A, S_B, S_RD2, S_DMEM, S_WB} sig_e;

    typedef struct {
        string       name;
        sig_e        sel;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstMem_Out;
    logic [31:0] PCOut, PC_In, A, B, rd2, datamem_out, mux5_out;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] pc_exp;
    logic [31:0] last_pc_in;

    modport_cpu #(.DMEM_WORDS(64), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .InstMem_Out (InstMem_Out),
        .PCOut       (PCOut),
        .PC_In       (PC_In),
        .A           (A),
        .B           (B),
        .rd2         (rd2),
        .datamem_out (datamem_out),
        .mux5_out    (mux5_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input sig_e s);
        case (s)
            S_PC:    return PCOut;
            S_PCIN:  return PC_In;
            S_A:     return A;
            S_B:     return B;
            S_RD2:   return rd2;
            S_DMEM:  return datamem_out;
            default: return mux5_out;
        endcase
    endfunction

    task automatic check(input exp_t e);
        logic [31:0] got;
        got = pick(e.sel);
        n_cmp++;
        if (got !== e.val) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", e.name, got, e.val, $time);
        end
    endtask

    // Monitor: the core presents fresh outputs every cycle, so everything
    // queued for the current cycle is compared mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) check(sb.pop_front());
    end

    task automatic put(input string name, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sel  = s;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Present one instruction; always expect current PC and next PC.
    task automatic issue(input string name, input logic [31:0] instr, input logic [31:0] pc_in);
        InstMem_Out = instr;
        last_pc_in  = pc_in;
        put({name, ".pc"},   S_PC,   pc_exp);
        put({name, ".pcin"}, S_PCIN, pc_in);
    endtask

    task automatic advance;
        @(posedge clk);
        #1;
        pc_exp = last_pc_in;
    endtask

    initial begin
        reset       = 1'b1;
        InstMem_Out = 32'h0;
        pc_exp      = 32'h0;
        last_pc_in  = 32'h0;
        @(posedge clk);
        #1;
        // Reset state with sll $0,$0,0 present
        issue("rst", 32'h0000_0000, 32'h4);
        put("rst.a", S_A, 0); put("rst.b", S_B, 0); put("rst.rd2", S_RD2, 0);
        put("rst.dmem", S_DMEM, 0); put("rst.wb", S_WB, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        pc_exp = 32'h0;

        issue("addi1", 32'h2001_0005, 32'h04);
        put("addi1.a", S_A, 0); put("addi1.b", S_B, 5); put("addi1.wb", S_WB, 5);
        advance();
        issue("addi2", 32'h2002_0007, 32'h08);
        put("addi2.wb", S_WB, 7);
        advance();
        issue("add", 32'h0022_1820, 32'h0C);
        put("add.a", S_A, 5); put("add.b", S_B, 7); put("add.wb", S_WB, 12);
        advance();
        issue("sll", 32'h0001_2880, 32'h10);
        put("sll.wb", S_WB, 20);
        advance();
        issue("sw", 32'hAC03_0008, 32'h14);
        put("sw.rd2", S_RD2, 12); put("sw.b", S_B, 8); put("sw.dmem_pre", S_DMEM, 0);
        advance();
        issue("lw", 32'h8C04_0008, 32'h18);
        put("lw.dmem", S_DMEM, 12); put("lw.wb", S_WB, 12);
        advance();
        issue("rd4", 32'h0080_0025, 32'h1C);      // or $0,$4,$0
        put("rd4.a", S_A, 12);
        advance();
        issue("wr0", 32'h2000_0009, 32'h20);      // addi $0,$0,9
        put("wr0.wb", S_WB, 9);
        advance();
        issue("rd0", 32'h0001_3820, 32'h24);      // add $7,$0,$1
        put("rd0.a", S_A, 0); put("rd0.b", S_B, 5); put("rd0.wb", S_WB, 5);
        advance();
        issue("beq_t", 32'h1021_0003, 32'h34);
        put("beq_t.a", S_A, 5); put("beq_t.b", S_B, 5);
        advance();
        issue("bne_t", 32'h1422_0003, 32'h44);
        advance();
        issue("beq_nt", 32'h1022_0003, 32'h48);
        advance();
        issue("bne_nt", 32'h1421_0003, 32'h4C);
        advance();
        issue("beq_neg", 32'h1000_FFFE, 32'h48);  // backward branch by 2 words
        advance();
        issue("j", 32'h0800_0010, 32'h40);
        advance();
        issue("undef", 32'hFC22_1820, 32'h44);    // opcode 0x3F with rd=$3 fields
        advance();
        issue("keep", 32'h0043_0020, 32'h48);     // add $0,$2,$3
        put("keep.a", S_A, 7); put("keep.b", S_B, 12); put("keep.wb", S_WB, 19);
        advance();
        issue("sub", 32'h0022_4022, 32'h4C);
        put("sub.wb", S_WB, 32'hFFFF_FFFE);
        advance();
        issue("slt", 32'h0101_482A, 32'h50);      // -2 < 5 signed
        put("slt.wb", S_WB, 1);
        advance();
        issue("slti", 32'h282A_FFFF, 32'h54);     // 5 < -1 -> 0
        put("slti.b", S_B, 32'hFFFF_FFFF); put("slti.wb", S_WB, 0);
        advance();
        issue("andi", 32'h310B_FFFF, 32'h58);
        put("andi.b", S_B, 32'h0000_FFFF); put("andi.wb", S_WB, 32'h0000_FFFE);
        advance();
        issue("ori", 32'h342C_8000, 32'h5C);
        put("ori.b", S_B, 32'h0000_8000); put("ori.wb", S_WB, 32'h0000_8005);
        advance();
        issue("and", 32'h0102_6824, 32'h60);
        put("and.wb", S_WB, 6);
        advance();
        issue("srl", 32'h0008_7702, 32'h64);
        put("srl.wb", S_WB, 32'h0000_000F);
        advance();
        issue("sw_wrap", 32'hAC01_0108, 32'h68);  // 0x108 aliases word 2 (addr 8)
        put("sw_wrap.rd2", S_RD2, 5);
        advance();
        issue("lw_wrap", 32'h8C0F_0008, 32'h6C);
        put("lw_wrap.dmem", S_DMEM, 5); put("lw_wrap.wb", S_WB, 5);
        advance();

        // Mid-program reset overriding a pending addi $1 write
        issue("mrst", 32'h2001_0077, 32'h70);
        reset = 1'b1;
        advance();
        reset  = 1'b0;
        pc_exp = 32'h0;
        issue("post_lw", 32'h8C04_0008, 32'h04);
        put("post_lw.dmem", S_DMEM, 0); put("post_lw.wb", S_WB, 0);
        advance();
        issue("post_rd", 32'h0023_0020, 32'h08);  // add $0,$1,$3
        put("post_rd.a", S_A, 0); put("post_rd.b", S_B, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
